// File: rtl/ysyx_23060020_lsu_pkg.sv
// Shared definitions for the ysyx_23060020 load/store unit: funct3 codes,
// FSM state encoding and the byte-strobe helper.
package ysyx_23060020_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  // Unshifted byte strobes for an access of 2**size bytes.
  function automatic logic [7:0] lsu_base_mask(input logic [1:0] size);
    case (size)
      2'd0:    lsu_base_mask = 8'h01;
      2'd1:    lsu_base_mask = 8'h03;
      2'd2:    lsu_base_mask = 8'h0F;
      default: lsu_base_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060020_lsu_if.sv
// Memory-side request/response bus of the LSU; master = LSU, slave = memory adapter.
interface ysyx_23060020_lsu_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_wmask;
  logic                mem_rsp_valid;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_23060020_lsu_align.sv
// Combinational lane steering: store shift and strobes, load extract/extend,
// and legality of the access.
module ysyx_23060020_lsu_align
  import ysyx_23060020_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              wen,
  input  logic [2:0]        funct3,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              illegal
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  logic [OFF_W-1:0] off;
  logic [OFF_W+2:0] shamt;
  logic [XLEN-1:0]  raw;

  assign off   = addr_lo[OFF_W-1:0];
  assign shamt = {off, 3'b000};

  always_comb begin
    wdata_sh = wdata << shamt;
    wmask    = wen ? NB'(16'(lsu_base_mask(funct3[1:0])) << off) : '0;
    raw      = rdata >> shamt;

    // Size casts of signed slices give the sign extension for b/h/w.
    case (funct3)
      LSU_B:   rdata_ext = XLEN'($signed(raw[7:0]));
      LSU_H:   rdata_ext = XLEN'($signed(raw[15:0]));
      LSU_W:   rdata_ext = XLEN'($signed(raw[31:0]));
      LSU_D:   rdata_ext = raw;
      LSU_BU:  rdata_ext = XLEN'(raw[7:0]);
      LSU_HU:  rdata_ext = XLEN'(raw[15:0]);
      LSU_WU:  rdata_ext = XLEN'(raw[31:0]);
      default: rdata_ext = '0;
    endcase

    case (funct3)
      LSU_B, LSU_BU: illegal = 1'b0;
      LSU_H, LSU_HU: illegal = addr_lo[0];
      LSU_W:         illegal = (addr_lo[1:0] != 2'b00);
      LSU_WU:        illegal = (addr_lo[1:0] != 2'b00) || (XLEN == 32) || wen;
      LSU_D:         illegal = (addr_lo != 3'b000) || (XLEN == 32);
      default:       illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060020_lsu.sv
// Multi-cycle load/store unit: IDLE -> REQ -> WAIT -> DONE handshake to memory,
// with illegal accesses completing directly from IDLE.
module ysyx_23060020_lsu
  import ysyx_23060020_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_valid,
  input  logic                   core_wen,
  input  logic [2:0]             core_funct3,
  input  logic [ADDR_W-1:0]      core_addr,
  input  logic [XLEN-1:0]        core_wdata,
  output logic [XLEN-1:0]        core_rdata,
  output logic                   core_done,
  output logic                   core_err,
  output logic                   core_busy,
  ysyx_23060020_lsu_if.master    mem
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  lsu_state_e  state;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [2:0]  addr_lo_q;

  logic            a_wen;
  logic [2:0]      a_funct3;
  logic [2:0]      a_addr_lo;
  logic [XLEN-1:0] wdata_sh;
  logic [NB-1:0]   wmask;
  logic [XLEN-1:0] rdata_ext;
  logic            illegal;

  // One aligner serves both phases: live core inputs while IDLE, latched
  // access attributes afterwards for the load extraction.
  assign a_wen     = (state == S_IDLE) ? core_wen         : wen_q;
  assign a_funct3  = (state == S_IDLE) ? core_funct3      : funct3_q;
  assign a_addr_lo = (state == S_IDLE) ? core_addr[2:0]   : addr_lo_q;

  ysyx_23060020_lsu_align #(.XLEN(XLEN)) u_align (
    .wen       (a_wen),
    .funct3    (a_funct3),
    .addr_lo   (a_addr_lo),
    .wdata     (core_wdata),
    .rdata     (mem.mem_rdata),
    .wdata_sh  (wdata_sh),
    .wmask     (wmask),
    .rdata_ext (rdata_ext),
    .illegal   (illegal)
  );

  assign core_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      wen_q             <= 1'b0;
      funct3_q          <= '0;
      addr_lo_q         <= '0;
      core_rdata        <= '0;
      core_done         <= 1'b0;
      core_err          <= 1'b0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_wen       <= 1'b0;
      mem.mem_wdata     <= '0;
      mem.mem_wmask     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_valid) begin
            wen_q     <= core_wen;
            funct3_q  <= core_funct3;
            addr_lo_q <= core_addr[2:0];
            if (illegal) begin
              core_err   <= 1'b1;
              core_rdata <= '0;
              core_done  <= 1'b1;
              state      <= S_DONE;
            end else begin
              mem.mem_req_valid <= 1'b1;
              mem.mem_addr      <= {core_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem.mem_wen       <= core_wen;
              mem.mem_wdata     <= wdata_sh;
              mem.mem_wmask     <= wmask;
              state             <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            mem.mem_addr      <= '0;
            mem.mem_wen       <= 1'b0;
            mem.mem_wdata     <= '0;
            mem.mem_wmask     <= '0;
            state             <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rsp_valid) begin
            core_rdata <= wen_q ? '0 : rdata_ext;
            core_err   <= 1'b0;
            core_done  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          core_done <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060020_lsu.sv
// Directed bench for ysyx_23060020_lsu with one XLEN=32 and one XLEN=64 instance.
module tb_ysyx_23060020_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v32, wen32, done32, err32, busy32;
  logic [2:0]  f32;
  logic [31:0] addr32, wd32, rd32;
  logic        v64, wen64, done64, err64, busy64;
  logic [2:0]  f64;
  logic [31:0] addr64;
  logic [63:0] wd64, rd64;

  int checks = 0;
  int errors = 0;

  ysyx_23060020_lsu_if #(.XLEN(32), .ADDR_W(32)) m32 ();
  ysyx_23060020_lsu_if #(.XLEN(64), .ADDR_W(32)) m64 ();

  ysyx_23060020_lsu #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .core_valid(v32), .core_wen(wen32), .core_funct3(f32),
    .core_addr(addr32), .core_wdata(wd32), .core_rdata(rd32), .core_done(done32),
    .core_err(err32), .core_busy(busy32), .mem(m32)
  );

  ysyx_23060020_lsu #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst), .core_valid(v64), .core_wen(wen64), .core_funct3(f64),
    .core_addr(addr64), .core_wdata(wd64), .core_rdata(rd64), .core_done(done64),
    .core_err(err64), .core_busy(busy64), .mem(m64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Runs one access with memory always ready/responding; checks latency,
  // the captured request fields and the result.
  task automatic run(input bit w64, input string tag, input logic wen, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] mrd,
                     input logic exp_err, input logic [31:0] exp_maddr, input logic [63:0] exp_mwd,
                     input logic [7:0] exp_mask, input logic [63:0] exp_rd);
    int n;
    logic saw, seen_done, cap_wen;
    logic [31:0] cap_addr;
    logic [63:0] cap_wd, o_rd;
    logic [7:0]  cap_mask;
    logic        o_err, o_done, o_busy;
    n = 0; saw = 1'b0; seen_done = 1'b0;
    cap_wen = 1'b0; cap_addr = '0; cap_wd = '0; cap_mask = '0;
    if (w64) begin
      v64 = 1'b1; wen64 = wen; f64 = f3; addr64 = addr; wd64 = wdata;
      m64.mem_req_ready = 1'b1; m64.mem_rsp_valid = 1'b1; m64.mem_rdata = mrd;
    end else begin
      v32 = 1'b1; wen32 = wen; f32 = f3; addr32 = addr; wd32 = wdata[31:0];
      m32.mem_req_ready = 1'b1; m32.mem_rsp_valid = 1'b1; m32.mem_rdata = mrd[31:0];
    end
    while (!seen_done && n < 10) begin
      tick();
      n++;
      v32 = 1'b0; v64 = 1'b0;
      if (!saw && (w64 ? m64.mem_req_valid : m32.mem_req_valid)) begin
        saw      = 1'b1;
        cap_addr = w64 ? m64.mem_addr : m32.mem_addr;
        cap_wen  = w64 ? m64.mem_wen  : m32.mem_wen;
        cap_wd   = w64 ? m64.mem_wdata : {32'h0, m32.mem_wdata};
        cap_mask = w64 ? m64.mem_wmask : {4'h0, m32.mem_wmask};
      end
      seen_done = w64 ? done64 : done32;
    end
    o_rd  = w64 ? rd64  : {32'h0, rd32};
    o_err = w64 ? err64 : err32;
    chk({tag, ".done"}, 64'(seen_done), 64'd1);
    chk({tag, ".latency"}, 64'(n), exp_err ? 64'd1 : 64'd3);
    chk({tag, ".err"}, 64'(o_err), 64'(exp_err));
    chk({tag, ".rdata"}, o_rd, exp_rd);
    chk({tag, ".req_seen"}, 64'(saw), 64'(!exp_err));
    if (saw) begin
      chk({tag, ".maddr"}, 64'(cap_addr), 64'(exp_maddr));
      chk({tag, ".mwen"}, 64'(cap_wen), 64'(wen));
      chk({tag, ".mwdata"}, cap_wd, exp_mwd);
      chk({tag, ".mwmask"}, 64'(cap_mask), 64'(exp_mask));
    end
    m32.mem_req_ready = 1'b0; m32.mem_rsp_valid = 1'b0;
    m64.mem_req_ready = 1'b0; m64.mem_rsp_valid = 1'b0;
    tick();
    o_done = w64 ? done64 : done32;
    o_busy = w64 ? busy64 : busy32;
    chk({tag, ".done_pulse"}, 64'(o_done), 64'd0);
    chk({tag, ".idle_after"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v32 = 0; wen32 = 0; f32 = 0; addr32 = 0; wd32 = 0;
    v64 = 0; wen64 = 0; f64 = 0; addr64 = 0; wd64 = 0;
    m32.mem_req_ready = 0; m32.mem_rsp_valid = 0; m32.mem_rdata = 0;
    m64.mem_req_ready = 0; m64.mem_rsp_valid = 0; m64.mem_rdata = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst.rdata32", 64'(rd32), 0);
    chk("rst.done32", 64'(done32), 0);
    chk("rst.err32", 64'(err32), 0);
    chk("rst.busy32", 64'(busy32), 0);
    chk("rst.reqv32", 64'(m32.mem_req_valid), 0);
    chk("rst.maddr32", 64'(m32.mem_addr), 0);
    chk("rst.mwen32", 64'(m32.mem_wen), 0);
    chk("rst.mwdata32", 64'(m32.mem_wdata), 0);
    chk("rst.mwmask32", 64'(m32.mem_wmask), 0);
    chk("rst.rdata64", rd64, 0);
    chk("rst.done64", 64'(done64), 0);
    chk("rst.busy64", 64'(busy64), 0);
    chk("rst.reqv64", 64'(m64.mem_req_valid), 0);

    // XLEN=32 stores
    run(0, "sb", 1, 3'b000, 32'h8000_0003, 64'hAB, 0, 0, 32'h8000_0000, 64'hAB00_0000, 8'h08, 0);
    run(0, "sh", 1, 3'b001, 32'h8000_0002, 64'hBEEF, 0, 0, 32'h8000_0000, 64'hBEEF_0000, 8'h0C, 0);
    run(0, "sw", 1, 3'b010, 32'h8000_0004, 64'hCAFE_F00D, 0, 0, 32'h8000_0004, 64'hCAFE_F00D, 8'h0F, 0);

    // XLEN=32 loads from word 0x80F17F01
    run(0, "lb1", 0, 3'b000, 32'h8000_1001, 0, 64'h80F1_7F01, 0, 32'h8000_1000, 0, 8'h00, 64'h0000_007F);
    run(0, "lb2", 0, 3'b000, 32'h8000_1002, 0, 64'h80F1_7F01, 0, 32'h8000_1000, 0, 8'h00, 64'hFFFF_FFF1);
    run(0, "lhu2", 0, 3'b101, 32'h8000_1002, 0, 64'h80F1_7F01, 0, 32'h8000_1000, 0, 8'h00, 64'h0000_80F1);
    run(0, "lh2", 0, 3'b001, 32'h8000_1002, 0, 64'h80F1_7F01, 0, 32'h8000_1000, 0, 8'h00, 64'hFFFF_80F1);
    run(0, "lw0", 0, 3'b010, 32'h8000_1000, 0, 64'h80F1_7F01, 0, 32'h8000_1000, 0, 8'h00, 64'h80F1_7F01);
    run(0, "lbu3", 0, 3'b100, 32'h8000_1003, 0, 64'h80F1_7F01, 0, 32'h8000_1000, 0, 8'h00, 64'h0000_0080);

    // XLEN=32 illegal accesses
    run(0, "lw_mis", 0, 3'b010, 32'h8000_1002, 0, 64'h80F1_7F01, 1, 0, 0, 0, 0);
    run(0, "lh_mis", 0, 3'b001, 32'h8000_1001, 0, 64'h80F1_7F01, 1, 0, 0, 0, 0);
    run(0, "ld_x32", 0, 3'b011, 32'h8000_1000, 0, 64'h80F1_7F01, 1, 0, 0, 0, 0);
    run(0, "s110", 1, 3'b110, 32'h8000_1000, 0, 0, 1, 0, 0, 0, 0);
    run(0, "l111", 0, 3'b111, 32'h8000_1000, 0, 0, 1, 0, 0, 0, 0);

    // Back-pressure: 5 cycles not ready, 3 cycles without response
    v32 = 1; wen32 = 0; f32 = 3'b101; addr32 = 32'h8000_0002; wd32 = 0;
    m32.mem_req_ready = 0; m32.mem_rsp_valid = 0; m32.mem_rdata = 32'h1234_ABCD;
    tick();
    v32 = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.reqv", 64'(m32.mem_req_valid), 1);
      chk("bp.maddr", 64'(m32.mem_addr), 64'h8000_0000);
      chk("bp.mwen", 64'(m32.mem_wen), 0);
      chk("bp.mwmask", 64'(m32.mem_wmask), 0);
      chk("bp.busy", 64'(busy32), 1);
      chk("bp.done", 64'(done32), 0);
      if (i == 1) begin v32 = 1; wen32 = 1; addr32 = 32'h0; end
      if (i == 2) begin v32 = 0; wen32 = 0; end
      tick();
    end
    m32.mem_req_ready = 1;
    tick();
    m32.mem_req_ready = 0;
    chk("bp.reqv_wait", 64'(m32.mem_req_valid), 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.wait_busy", 64'(busy32), 1);
      chk("bp.wait_done", 64'(done32), 0);
      tick();
    end
    m32.mem_rsp_valid = 1;
    tick();
    m32.mem_rsp_valid = 0;
    chk("bp.done_now", 64'(done32), 1);
    chk("bp.rdata", 64'(rd32), 64'h0000_1234);
    chk("bp.err", 64'(err32), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.done_once", 64'(done32), 0);
      chk("bp.idle", 64'(busy32), 0);
      chk("bp.no_new_req", 64'(m32.mem_req_valid), 0);
    end

    // Reset while waiting for a response, then a stray response in IDLE
    v32 = 1; wen32 = 0; f32 = 3'b010; addr32 = 32'h8000_0010;
    m32.mem_req_ready = 1; m32.mem_rsp_valid = 0;
    tick();
    v32 = 0;
    tick();
    chk("rw.busy", 64'(busy32), 1);
    chk("rw.reqv", 64'(m32.mem_req_valid), 0);
    rst = 1; m32.mem_req_ready = 0;
    tick();
    rst = 0; m32.mem_rsp_valid = 1; m32.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rw.done", 64'(done32), 0);
    chk("rw.rdata", 64'(rd32), 0);
    chk("rw.err", 64'(err32), 0);
    chk("rw.busy_after", 64'(busy32), 0);
    chk("rw.reqv_after", 64'(m32.mem_req_valid), 0);
    tick();
    chk("rw.done2", 64'(done32), 0);
    m32.mem_rsp_valid = 0;

    // XLEN=64 accesses
    run(1, "ld", 0, 3'b011, 32'h8000_0008, 0, 64'h0123_4567_89AB_CDEF, 0, 32'h8000_0008, 0, 8'h00,
        64'h0123_4567_89AB_CDEF);
    run(1, "lwu4", 0, 3'b110, 32'h8000_0004, 0, 64'hFFFF_FFFF_0000_0000, 0, 32'h8000_0000, 0, 8'h00,
        64'h0000_0000_FFFF_FFFF);
    run(1, "lw4", 0, 3'b010, 32'h8000_0004, 0, 64'h8000_0000_0000_0000, 0, 32'h8000_0000, 0, 8'h00,
        64'hFFFF_FFFF_8000_0000);
    run(1, "lbu7", 0, 3'b100, 32'h8000_0007, 0, 64'hA500_0000_0000_0000, 0, 32'h8000_0000, 0, 8'h00,
        64'h0000_0000_0000_00A5);
    run(1, "sd_mis", 1, 3'b011, 32'h8000_0004, 64'h1122_3344_5566_7788, 0, 1, 0, 0, 0, 0);
    run(1, "sd", 1, 3'b011, 32'h8000_0008, 64'h1122_3344_5566_7788, 0, 0, 32'h8000_0008,
        64'h1122_3344_5566_7788, 8'hFF, 0);
    run(1, "sh6", 1, 3'b001, 32'h8000_0006, 64'h1234, 0, 0, 32'h8000_0000,
        64'h1234_0000_0000_0000, 8'hC0, 0);
    run(1, "s110_64", 1, 3'b110, 32'h8000_0000, 0, 0, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
